serial_frame_receiver: RTL and testbench

Serial-to-parallel frame receiver, the receive end of the shift-register link. A universal shift register loaded in parallel and shifted out one bit per strobe produces the serial stream this block consumes. It detects a start bit, shifts in N data bits in LSB-first or MSB-first order, checks a stop bit, and presents the assembled word on a valid/ack handshake. Framing errors and overruns are flagged.

---
 rtl/serial_frame_receiver_if.sv | 26 ++
 rtl/serial_frame_receiver.sv | 103 ++++++++++
 tb/tb_serial_frame_receiver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_if.sv
// Serial frame receiver bus: serial line, bit strobe and order select toward
// the receiver; received word with valid/ack handshake and error pulses back.
//   master : serial source / word consumer (drives sin, sen, msb_first, ack)
//   slave  : receiver (drives q, valid, ferr, ovr)
interface serial_frame_receiver_if #(
    parameter int unsigned N = 8
);
    logic         sin;
    logic         sen;
    logic         msb_first;
    logic         ack;
    logic [N-1:0] q;
    logic         valid;
    logic         ferr;
    logic         ovr;

    modport master (
        output sin, sen, msb_first, ack,
        input  q, valid, ferr, ovr
    );

    modport slave (
        input  sin, sen, msb_first, ack,
        output q, valid, ferr, ovr
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit, N data bits (LSB- or
// MSB-first), stop bit. The assembled word is presented on a valid/ack
// handshake; bad stop bits pulse ferr, and a good frame overwriting an
// unacknowledged word pulses ovr.
//   clk   : rising-edge clock
//   nrst  : asynchronous active-low reset
//   bus   : slave side of serial_frame_receiver_if
//           sin/sen/msb_first/ack in, q/valid/ferr/ovr out (all registered)
module serial_frame_receiver #(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    serial_frame_receiver_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        RESYNC
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sh;
    logic          ord;
    logic [N-1:0]  q_r;
    logic          valid_r;
    logic          ferr_r;
    logic          ovr_r;

    // Frame reception, handshake and error pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            ord     <= 1'b0;
            q_r     <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;

            // Consumer acknowledge; a good stop on this edge overrides below
            if (valid_r && bus.ack) begin
                valid_r <= 1'b0;
            end

            if (bus.sen) begin
                case (state)
                    IDLE: begin
                        if (!bus.sin) begin
                            state <= DATA;
                            cnt   <= '0;
                            ord   <= bus.msb_first;
                        end
                    end
                    DATA: begin
                        if (ord) begin
                            sh <= {sh[N-2:0], bus.sin};
                        end else begin
                            sh <= {bus.sin, sh[N-1:1]};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (bus.sin) begin
                            q_r     <= sh;
                            valid_r <= 1'b1;
                            ovr_r   <= valid_r && !bus.ack;
                            state   <= IDLE;
                        end else begin
                            ferr_r <= 1'b1;
                            state  <= RESYNC;
                        end
                    end
                    RESYNC: begin
                        // Wait for the line to return high before hunting a start bit
                        if (bus.sin) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.q     = q_r;
    assign bus.valid = valid_r;
    assign bus.ferr  = ferr_r;
    assign bus.ovr   = ovr_r;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with a frame-level model: the
// expected word comes from the frame being sent, not from reassembled bits.
module tb_serial_frame_receiver;
    localparam int unsigned N = 8;

    typedef enum int {EV_NONE, EV_GOOD, EV_BAD} ev_t;

    logic clk;
    logic nrst;

    serial_frame_receiver_if #(.N(N)) bus ();

    serial_frame_receiver #(.N(N)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

    logic [N-1:0] exp_q;
    logic         exp_valid;
    logic         exp_ferr;
    logic         exp_ovr;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the frame-level model
    always @(negedge clk) begin
        if (chk_en) begin
            check("q",     32'(bus.q),     32'(exp_q));
            check("valid", 32'(bus.valid), 32'(exp_valid));
            check("ferr",  32'(bus.ferr),  32'(exp_ferr));
            check("ovr",   32'(bus.ovr),   32'(exp_ovr));
        end
    end

    // One clock edge; ev says what the frame stream completes on this edge
    task automatic tick(input ev_t ev, input logic [N-1:0] word);
        logic ack_now;
        logic v_before;
        ack_now  = bus.ack;
        v_before = exp_valid;
        @(posedge clk);
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (v_before && ack_now) exp_valid = 1'b0;
        if (ev == EV_GOOD) begin
            exp_ovr   = v_before && !ack_now;
            exp_q     = word;
            exp_valid = 1'b1;
        end else if (ev == EV_BAD) begin
            exp_ferr = 1'b1;
        end
        #1;
    endtask

    // One strobed sample, then gap unstrobed cycles with the line toggled
    task automatic sample(input logic b, input ev_t ev, input logic [N-1:0] word, input int gap);
        bus.sin = b;
        bus.sen = 1'b1;
        tick(ev, word);
        bus.sen = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.sin = ~b;
            tick(EV_NONE, '0);
        end
    endtask

    task automatic send_frame(input logic [N-1:0] data, input logic msbf, input logic stop_b,
                              input int gap, input logic ack_stop, input logic toggle);
        logic b;
        bus.msb_first = msbf;
        sample(1'b0, EV_NONE, '0, gap);
        for (int i = 0; i < int'(N); i++) begin
            if (toggle && i > 0) bus.msb_first = ~bus.msb_first;
            b = msbf ? data[N-1-i] : data[i];
            sample(b, EV_NONE, '0, gap);
        end
        bus.ack = ack_stop;
        sample(stop_b, stop_b ? EV_GOOD : EV_BAD, data, 0);
        bus.ack = 1'b0;
        for (int g = 0; g < gap; g++) tick(EV_NONE, '0);
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick(EV_NONE, '0);
        bus.ack = 1'b0;
    endtask

    logic [9:0] usr;

    initial begin
        bus.sin       = 1'b1;
        bus.sen       = 1'b0;
        bus.msb_first = 1'b0;
        bus.ack       = 1'b0;
        nrst          = 1'b0;
        exp_q         = '0;
        exp_valid     = 1'b0;
        exp_ferr      = 1'b0;
        exp_ovr       = 1'b0;

        #22;
        check("reset_q",     32'(bus.q),     32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_ferr",  32'(bus.ferr),  32'h0);
        check("reset_ovr",   32'(bus.ovr),   32'h0);
        nrst   = 1'b1;
        chk_en = 1'b1;
        tick(EV_NONE, '0);
        tick(EV_NONE, '0);

        // LSB-first 0xA5, then acknowledge
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("lsb_q",     32'(bus.q),     32'hA5);
        check("lsb_valid", 32'(bus.valid), 32'h1);
        ack_pulse();
        check("ack_valid", 32'(bus.valid), 32'h0);
        check("ack_q",     32'(bus.q),     32'hA5);

        // MSB-first 0xC1, strobe every 3rd cycle, msb_first toggling mid-frame
        send_frame(8'hC1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        check("msb_q",     32'(bus.q),     32'hC1);
        check("msb_valid", 32'(bus.valid), 32'h1);

        // Bad stop on 0x3C, line held low, then recovery with 0x5A
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("ferr_pulse", 32'(bus.ferr), 32'h1);
        check("ferr_q",     32'(bus.q),    32'hC1);
        for (int k = 0; k < 5; k++) sample(1'b0, EV_NONE, '0, 0);
        sample(1'b1, EV_NONE, '0, 0);
        check("ferr_clear", 32'(bus.ferr), 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("resync_q", 32'(bus.q), 32'h5A);

        // Back-to-back frames without ack: overrun
        ack_pulse();
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(bus.ovr),   32'h1);
        check("ovr_q",     32'(bus.q),     32'h22);
        check("ovr_valid", 32'(bus.valid), 32'h1);

        // Same, with ack coinciding with the second stop bit: no overrun
        ack_pulse();
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        check("ackstop_ovr",   32'(bus.ovr),   32'h0);
        check("ackstop_q",     32'(bus.q),     32'h22);
        check("ackstop_valid", 32'(bus.valid), 32'h1);

        // Asynchronous reset after 4 data bits, then a clean 0xF0
        bus.msb_first = 1'b0;
        sample(1'b0, EV_NONE, '0, 0);
        for (int k = 0; k < 4; k++) sample(1'b1, EV_NONE, '0, 0);
        #2;
        nrst      = 1'b0;
        exp_q     = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        #1;
        check("arst_q",     32'(bus.q),     32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        check("arst_ferr",  32'(bus.ferr),  32'h0);
        check("arst_ovr",   32'(bus.ovr),   32'h0);
        bus.sin = 1'b1;
        tick(EV_NONE, '0);
        tick(EV_NONE, '0);
        #2;
        nrst = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("post_rst_q",     32'(bus.q),     32'hF0);
        check("post_rst_valid", 32'(bus.valid), 32'h1);

        // Loopback from a right-shifting universal shift register
        ack_pulse();
        usr = {1'b1, 8'h96, 1'b0};
        for (int k = 0; k < 10; k++) begin
            sample(usr[0], (k == 9) ? EV_GOOD : EV_NONE, 8'h96, 0);
            usr = {1'b1, usr[9:1]};
        end
        check("loop_q",     32'(bus.q),     32'h96);
        check("loop_valid", 32'(bus.valid), 32'h1);
        check("loop_ferr",  32'(bus.ferr),  32'h0);
        check("loop_ovr",   32'(bus.ovr),   32'h0);

        tick(EV_NONE, '0);
        tick(EV_NONE, '0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
